// File: rtl/byte_word_packer.sv
// byte_word_packer: collects NUM_BYTES_IN-byte chunks into NUM_BYTES_OUT-byte
// words and presents them on a registered valid/ready output with a byte count.
// A chunk flagged with in_last flushes a partial word, aligned to the end the
// first chunk occupies, with the unused bytes zero.

module byte_word_packer #(
  parameter int MSB           = 1,
  parameter int NUM_BYTES_IN  = 1,
  parameter int NUM_BYTES_OUT = 4
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_BYTES_IN*8-1:0]        in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_BYTES_OUT*8-1:0]       out_data,
  output logic [$clog2(NUM_BYTES_OUT):0]   out_count,
  output logic                             out_last
);

  localparam int K    = NUM_BYTES_OUT / NUM_BYTES_IN;
  localparam int CW   = NUM_BYTES_IN * 8;
  localparam int OW   = NUM_BYTES_OUT * 8;
  localparam int CNTW = $clog2(K) + 1;
  localparam int OCW  = $clog2(NUM_BYTES_OUT) + 1;

  // The shift datapath only makes sense when a word is a whole number (>1) of chunks.
  generate
    if ((NUM_BYTES_IN < 1) || (NUM_BYTES_OUT <= NUM_BYTES_IN) ||
        ((NUM_BYTES_OUT % NUM_BYTES_IN) != 0)) begin : g_bad_params
      $fatal(1, "byte_word_packer: NUM_BYTES_OUT must be a multiple of NUM_BYTES_IN and larger than it");
    end
  endgenerate

  typedef enum logic [0:0] {
    EMPTY   = 1'b0,
    FILLING = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] count_next;
  logic [OW-1:0]   coll;
  logic [OW-1:0]   coll_next;
  logic [OW-1:0]   coll_shift;
  logic [OW-1:0]   word_next;
  logic [OCW-1:0]  count_word;
  logic            accept;
  logic            take;
  logic            complete;
  int              pad_bits;

  // Input only stalls while a finished word is held by the consumer.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign take     = out_valid & out_ready;

  // Shift the incoming chunk into the collection and align a possibly partial word.
  always_comb begin
    coll_shift = coll;
    word_next  = '0;
    pad_bits   = (K - 1 - int'(count)) * CW;
    count_word = OCW'((int'(count) + 1) * NUM_BYTES_IN);
    if (MSB != 0) begin
      coll_shift = {coll[OW-CW-1:0], in_data};
      word_next  = coll_shift << pad_bits;
    end else begin
      coll_shift = {in_data, coll[OW-1:CW]};
      word_next  = coll_shift >> pad_bits;
    end
  end

  // Collection FSM: decide completion and the next chunk count/collection contents.
  always_comb begin
    state_next = state;
    count_next = count;
    coll_next  = coll;
    complete   = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          if (in_last) begin
            complete   = 1'b1;
            state_next = EMPTY;
            count_next = '0;
            coll_next  = '0;
          end else begin
            state_next = FILLING;
            count_next = CNTW'(1);
            coll_next  = coll_shift;
          end
        end else begin
          state_next = EMPTY;
        end
      end
      FILLING: begin
        if (accept) begin
          if (in_last || (count == CNTW'(K - 1))) begin
            complete   = 1'b1;
            state_next = EMPTY;
            count_next = '0;
            coll_next  = '0;
          end else begin
            state_next = FILLING;
            count_next = count + CNTW'(1);
            coll_next  = coll_shift;
          end
        end else begin
          state_next = FILLING;
        end
      end
      default: begin
        state_next = EMPTY;
        count_next = '0;
        coll_next  = '0;
      end
    endcase
  end

  // State register for the collection FSM and its chunk counter / collection.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= EMPTY;
      count <= '0;
      coll  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      coll  <= coll_next;
    end
  end

  // Output register: load on completion, drop valid on a take, otherwise hold.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_data  <= word_next;
      out_count <= count_word;
      out_last  <= in_last;
    end else if (take) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule
